dp_ctrl: RTL and testbench

Multi-cycle control unit for the data-processing CPU, sitting directly downstream of the instruction-fetch stage. It sequences fetch, decode, execute and write-back, and drives the fetch stage's Write_PC/Write_IR strobes. It consumes the fetch stage's 28-bit IR and condition-pass flag. It decodes data-processing operand fields for the register file, shifter and ALU, and keeps executed and skipped instruction counters.

---
 rtl/dp_ctrl_if.sv | 15 +
 rtl/dp_ctrl.sv | 139 +++++++++++++
 tb/tb_dp_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/dp_ctrl_if.sv
// dp_ctrl_if: link between the instruction-fetch stage and the control unit.
//   IR        28  latched instruction bits, IR[n] holds ARM bit n-1
//   flag       1  condition-pass result for the instruction at the ROM output
//   Write_PC   1  advance the PC (fetch stage acts on the negedge)
//   Write_IR   1  load IR (fetch stage acts on the negedge)
// master = control unit (drives the strobes), slave = fetch stage.
interface dp_ctrl_if;
    logic [28:1] IR;
    logic        flag;
    logic        Write_PC;
    logic        Write_IR;

    modport master (output Write_PC, Write_IR, input IR, flag);
    modport slave  (input Write_PC, Write_IR, output IR, flag);
endinterface

// File: rtl/dp_ctrl.sv
// dp_ctrl: multi-cycle control unit for the data-processing CPU.
// Sequences IDLE -> FETCH -> DECODE -> EXEC -> WB, decodes the operand
// fields of data-processing instructions and counts executed / skipped
// instructions.
// Ports:
//   clk, Rst        clock (posedge) and asynchronous active-low reset
//   fbus            fetch-stage link (IR, flag in; Write_PC, Write_IR out)
//   Write_Reg       register-file write enable (WB only)
//   Write_NZCV      flag-register write enable (EXEC with S=1)
//   ALU_OP          opcode field
//   Rn/Rd/Rm/Rs     register addresses
//   Imm_sel, imm32  immediate operand2 select and rotated value
//   Shift_*         shifter control fields
//   Undef           illegal-instruction pulse in DECODE
//   State           current state, debug only
//   Exec_cnt/Skip_cnt  16-bit wrapping instruction counters
module dp_ctrl (
    input  logic        clk,
    input  logic        Rst,
    dp_ctrl_if.master   fbus,
    output logic        Write_Reg,
    output logic        Write_NZCV,
    output logic [3:0]  ALU_OP,
    output logic [3:0]  Rn_addr,
    output logic [3:0]  Rd_addr,
    output logic [3:0]  Rm_addr,
    output logic [3:0]  Rs_addr,
    output logic        Imm_sel,
    output logic [31:0] imm32,
    output logic [1:0]  Shift_type,
    output logic [4:0]  Shift_imm,
    output logic        Shift_by_reg,
    output logic        Undef,
    output logic [2:0]  State,
    output logic [15:0] Exec_cnt,
    output logic [15:0] Skip_cnt
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4
    } state_t;

    state_t      state;
    logic [3:0]  f_op;
    logic        f_s;
    logic        f_i;
    logic [1:0]  f_cls;   // ARM bits 27:26, must be 00 for data processing
    logic [3:0]  f_rn;
    logic [3:0]  f_rd;
    logic [11:0] f_lo;    // ARM bits 11:0 (shift/immediate/Rm area)
    logic [15:0] exec_cnt;
    logic [15:0] skip_cnt;
    logic        illegal;
    logic        is_cmp;

    // Compare-class opcodes (TST/TEQ/CMP/CMN) only make sense with S set
    // and never write a register.
    assign is_cmp  = (f_op[3:2] == 2'b10);
    assign illegal = (f_cls != 2'b00)
                   | (~f_i & f_lo[4] & f_lo[7])
                   | (is_cmp & ~f_s);

    // Fields are captured on the edge that leaves FETCH with flag=1; the
    // fetch stage loaded IR on the negedge before it, so IR is stable here
    // and the field outputs are valid for the whole DECODE cycle.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state    <= IDLE;
            f_op     <= '0;
            f_s      <= 1'b0;
            f_i      <= 1'b0;
            f_cls    <= '0;
            f_rn     <= '0;
            f_rd     <= '0;
            f_lo     <= '0;
            exec_cnt <= '0;
            skip_cnt <= '0;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (fbus.flag) begin
                        state <= DECODE;
                        f_cls <= fbus.IR[28:27];
                        f_i   <= fbus.IR[26];
                        f_op  <= fbus.IR[25:22];
                        f_s   <= fbus.IR[21];
                        f_rn  <= fbus.IR[20:17];
                        f_rd  <= fbus.IR[16:13];
                        f_lo  <= fbus.IR[12:1];
                    end else begin
                        state    <= FETCH;
                        skip_cnt <= skip_cnt + 16'd1;
                    end
                end
                DECODE: state <= illegal ? FETCH : EXEC;
                EXEC: begin
                    exec_cnt <= exec_cnt + 16'd1;
                    state    <= is_cmp ? FETCH : WB;
                end
                WB:      state <= FETCH;
                default: state <= IDLE;  // unused encodings recover
            endcase
        end
    end

    // Moore strobes: decoded from the state register (plus captured S),
    // so they never glitch while the fetch stage samples on the negedge.
    assign fbus.Write_PC = (state == FETCH);
    assign fbus.Write_IR = (state == FETCH);
    assign Write_Reg     = (state == WB);
    assign Write_NZCV    = (state == EXEC) & f_s;
    assign Undef         = (state == DECODE) & illegal;
    assign State         = state;

    assign ALU_OP       = f_op;
    assign Rn_addr      = f_rn;
    assign Rd_addr      = f_rd;
    assign Rm_addr      = f_lo[3:0];
    assign Rs_addr      = f_lo[11:8];
    assign Imm_sel      = f_i;
    assign Shift_type   = f_lo[6:5];
    assign Shift_imm    = f_lo[11:7];
    assign Shift_by_reg = ~f_i & f_lo[4];

    // imm32 = imm8 rotated right by 2*rot. With rot=0 the left shift by 32
    // yields zero, leaving the plain zero-extended imm8.
    logic [31:0] imm_z;
    logic [4:0]  imm_sh;
    assign imm_z  = {24'b0, f_lo[7:0]};
    assign imm_sh = {f_lo[11:8], 1'b0};
    assign imm32  = (imm_z >> imm_sh) | (imm_z << (6'd32 - {1'b0, imm_sh}));

    assign Exec_cnt = exec_cnt;
    assign Skip_cnt = skip_cnt;
endmodule

// File: tb/tb_dp_ctrl.sv
module tb_dp_ctrl;
    logic        clk;
    logic        Rst;
    logic        Write_Reg, Write_NZCV, Imm_sel, Shift_by_reg, Undef;
    logic [3:0]  ALU_OP, Rn_addr, Rd_addr, Rm_addr, Rs_addr;
    logic [31:0] imm32;
    logic [1:0]  Shift_type;
    logic [4:0]  Shift_imm;
    logic [2:0]  State;
    logic [15:0] Exec_cnt, Skip_cnt;

    dp_ctrl_if fb ();

    dp_ctrl dut (
        .clk(clk), .Rst(Rst), .fbus(fb),
        .Write_Reg(Write_Reg), .Write_NZCV(Write_NZCV), .ALU_OP(ALU_OP),
        .Rn_addr(Rn_addr), .Rd_addr(Rd_addr), .Rm_addr(Rm_addr), .Rs_addr(Rs_addr),
        .Imm_sel(Imm_sel), .imm32(imm32), .Shift_type(Shift_type),
        .Shift_imm(Shift_imm), .Shift_by_reg(Shift_by_reg), .Undef(Undef),
        .State(State), .Exec_cnt(Exec_cnt), .Skip_cnt(Skip_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  st;
        logic        wpc, wir, wreg, wnzcv, und;
        logic        fld;
        logic [3:0]  op, rn, rd, rm;
        logic        isel, sbr;
        logic [31:0] imm;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] m_exec = 16'd0;
    logic [15:0] m_skip = 16'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ror_imm(input logic [31:0] w);
        logic [31:0] v;
        v = {24'b0, w[7:0]};
        for (int i = 0; i < 2 * int'(w[11:8]); i++) v = {v[0], v[31:1]};
        return v;
    endfunction

    function automatic exp_t mk(input logic [2:0] st, input logic wreg, input logic wnzcv,
                                input logic und);
        exp_t e;
        e = '{st: st, wpc: (st == 3'd1), wir: (st == 3'd1), wreg: wreg, wnzcv: wnzcv,
              und: und, fld: 1'b0, op: 4'd0, rn: 4'd0, rd: 4'd0, rm: 4'd0,
              isel: 1'b0, sbr: 1'b0, imm: 32'd0};
        return e;
    endfunction

    task automatic check_cycle();
        exp_t e;
        e = sb.pop_front();
        chk("state", State, e.st);
        chk("write_pc", fb.Write_PC, e.wpc);
        chk("write_ir", fb.Write_IR, e.wir);
        chk("write_reg", Write_Reg, e.wreg);
        chk("write_nzcv", Write_NZCV, e.wnzcv);
        chk("undef", Undef, e.und);
        if (e.fld) begin
            chk("alu_op", ALU_OP, e.op);
            chk("rn", Rn_addr, e.rn);
            chk("rd", Rd_addr, e.rd);
            chk("rm", Rm_addr, e.rm);
            chk("imm_sel", Imm_sel, e.isel);
            chk("shift_by_reg", Shift_by_reg, e.sbr);
            chk("imm32", imm32, e.imm);
        end
    endtask

    // Called at a negedge while the DUT is in FETCH. Pushes the expected
    // per-cycle outputs, then compares one entry per cycle.
    task automatic run(input logic [31:0] w, input logic fl);
        exp_t e;
        logic und, s, cmp;
        fb.IR   = w[27:0];
        fb.flag = fl;
        und = (w[27:26] != 2'b00) || (!w[25] && w[4] && w[7]) ||
              (w[24:23] == 2'b10 && !w[20]);
        s   = w[20];
        cmp = (w[24:23] == 2'b10);
        sb.push_back(mk(3'd1, 1'b0, 1'b0, 1'b0));
        if (!fl) begin
            m_skip = m_skip + 16'd1;
        end else begin
            e = mk(3'd2, 1'b0, 1'b0, und);
            e.fld = 1'b1; e.op = w[24:21]; e.rn = w[19:16]; e.rd = w[15:12];
            e.rm = w[3:0]; e.isel = w[25]; e.sbr = !w[25] && w[4]; e.imm = ror_imm(w);
            sb.push_back(e);
            if (!und) begin
                sb.push_back(mk(3'd3, 1'b0, s, 1'b0));
                m_exec = m_exec + 16'd1;
                if (!cmp) sb.push_back(mk(3'd4, 1'b1, 1'b0, 1'b0));
            end
        end
        while (sb.size() > 0) begin
            check_cycle();
            @(negedge clk);
        end
        chk("exec_cnt", Exec_cnt, m_exec);
        chk("skip_cnt", Skip_cnt, m_skip);
    endtask

    initial begin
        Rst = 1'b0;
        fb.IR = '0;
        fb.flag = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", State, 3'd0);
        chk("rst_strobes", {fb.Write_PC, fb.Write_IR, Write_Reg, Write_NZCV, Undef}, 5'd0);
        chk("rst_imm32", imm32, 32'd0);
        chk("rst_fields", {ALU_OP, Rn_addr, Rd_addr, Rm_addr, Rs_addr}, 20'd0);
        chk("rst_cnt", {Exec_cnt, Skip_cnt}, 32'd0);
        Rst = 1'b1;
        chk("rel_idle", State, 3'd0);
        @(negedge clk);
        chk("rel_fetch", State, 3'd1);

        run(32'hE0821003, 1'b1);   // ADD R1,R2,R3
        run(32'hE3A004FF, 1'b1);   // MOV R0,#0xFF000000
        run(32'hE3A0007F, 1'b1);   // MOV R0,#0x7F (rot=0)
        run(32'hE3510005, 1'b1);   // CMP R1,#5
        run(32'hE0921312, 1'b1);   // ADDS R1,R2,R2 LSL R3
        repeat (3) run(32'hE0821003, 1'b0);  // condition failed
        run(32'hE0000091, 1'b1);   // MUL -> undefined
        run(32'hE5912000, 1'b1);   // LDR -> undefined (bits 27:26)
        run(32'hE1000001, 1'b1);   // compare opcode with S=0 -> undefined

        // Reset in the middle of EXEC aborts the instruction.
        fb.IR = 28'h0821003;
        fb.flag = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_exec", State, 3'd3);
        #2 Rst = 1'b0;
        #1;
        chk("async_rst_state", State, 3'd0);
        chk("async_rst_wb", {Write_Reg, Write_NZCV}, 2'd0);
        chk("async_rst_fields", {ALU_OP, Rn_addr, Rd_addr}, 12'd0);
        chk("async_rst_cnt", Exec_cnt, 16'd0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_no_wreg", Write_Reg, 1'b0);
        end
        m_exec = 16'd0;
        m_skip = 16'd0;
        Rst = 1'b1;
        @(negedge clk);
        chk("rerel_fetch", State, 3'd1);

        // Exec counter wrap: preload to 0xFFFF, then one compare instruction.
        force dut.exec_cnt = 16'hFFFF;
        #1 release dut.exec_cnt;
        m_exec = 16'hFFFF;
        run(32'hE3510005, 1'b1);
        chk("exec_wrap", Exec_cnt, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
